// File: rtl/s_axi_regbank_pkg.sv
// Shared types and helpers for the AXI4 slave register bank.
// Helpers work at the widest supported data width; callers cast to size.
package s_axi_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    localparam int MAX_DW = 128;
    localparam int MAX_SW = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_v,
        input logic [MAX_DW-1:0] new_v,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] r;
        r = old_v;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [MAX_DW-1:0] csum_fold(
        input logic [MAX_DW-1:0] acc,
        input logic [MAX_DW-1:0] v
    );
        return acc ^ v;
    endfunction

endpackage

// File: rtl/s_axi_regbank_if.sv
// AXI4 single-beat bus bundle for the register bank.
// Signal names keep the slave-side direction affixes.
interface s_axi_regbank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid_i;
    logic [ADDR_WIDTH-1:0]   awaddr_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] wstrb_i;
    logic                    wlast_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [ID_WIDTH-1:0]     bid_o;
    logic [1:0]              bresp_o;
    logic                    bvalid_o;
    logic                    bready_i;
    logic [ID_WIDTH-1:0]     arid_i;
    logic [ADDR_WIDTH-1:0]   araddr_i;
    logic                    arvalid_i;
    logic                    arready_o;
    logic [ID_WIDTH-1:0]     rid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic [1:0]              rresp_o;
    logic                    rlast_o;
    logic                    rvalid_o;
    logic                    rready_i;

    modport slave (
        input  awid_i, awaddr_i, awvalid_i,
        output awready_o,
        input  wdata_i, wstrb_i, wlast_i, wvalid_i,
        output wready_o,
        output bid_o, bresp_o, bvalid_o,
        input  bready_i,
        input  arid_i, araddr_i, arvalid_i,
        output arready_o,
        output rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        input  rready_i
    );

    modport master (
        output awid_i, awaddr_i, awvalid_i,
        input  awready_o,
        output wdata_i, wstrb_i, wlast_i, wvalid_i,
        input  wready_o,
        input  bid_o, bresp_o, bvalid_o,
        output bready_i,
        output arid_i, araddr_i, arvalid_i,
        input  arready_o,
        input  rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
        output rready_i
    );
endinterface

// File: rtl/s_axi_regbank_hold_slot.sv
// Single-entry valid/ready holding register.
// Accepts one beat while empty; emptied only by clear.
module axi_hold_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);
    assign in_ready = !areset && !full;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/s_axi_regbank.sv
// Parametrised AXI4 slave register bank with parallel register export.
// Define S_AXI_REGBANK_CSUM_EN to expose an XOR checksum at index REG_COUNT.
module s_axi_regbank
    import s_axi_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int REG_COUNT  = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    s_axi_regbank_if.slave        s_axi,
    output logic [DATA_WIDTH-1:0] m_regs_o [REG_COUNT],
    output logic [REG_COUNT-1:0]  m_reg_wr_o
);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(SW);
    localparam int AWP   = ID_WIDTH + ADDR_WIDTH;
    localparam int WP    = DATA_WIDTH + SW + 1;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic                  aw_full;
    logic                  w_full;
    logic [AWP-1:0]        aw_q;
    logic [WP-1:0]         w_q;
    logic [ADDR_WIDTH-1:0] aw_idx_in;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;
    logic                  w_last;

    logic                  commit;
    logic                  wr_ok;
    logic                  wr_en;
    logic                  b_valid;
    logic [ID_WIDTH-1:0]   b_id;
    axi_resp_t             b_resp;

    logic [ADDR_WIDTH-1:0] ar_idx;
    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] rd_data;
    axi_resp_t             rd_resp;
    logic                  r_valid;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    axi_resp_t             r_resp;

    assign aw_idx_in = s_axi.awaddr_i >> SHIFT;

    axi_hold_slot #(.W(AWP)) u_aw_slot (
        .clk      (clk),
        .areset   (areset),
        .in_valid (s_axi.awvalid_i),
        .in_ready (s_axi.awready_o),
        .in_data  ({s_axi.awid_i, aw_idx_in}),
        .clear    (commit),
        .full     (aw_full),
        .data     (aw_q)
    );

    axi_hold_slot #(.W(WP)) u_w_slot (
        .clk      (clk),
        .areset   (areset),
        .in_valid (s_axi.wvalid_i),
        .in_ready (s_axi.wready_o),
        .in_data  ({s_axi.wdata_i, s_axi.wstrb_i, s_axi.wlast_i}),
        .clear    (commit),
        .full     (w_full),
        .data     (w_q)
    );

    assign {aw_id, aw_idx}          = aw_q;
    assign {w_data, w_strb, w_last} = w_q;

    assign commit = aw_full && w_full && (!b_valid || s_axi.bready_i);
    // The checksum slot sits at REG_COUNT, so it already falls out of range here.
    assign wr_ok  = w_last && (aw_idx < ADDR_WIDTH'(REG_COUNT));
    assign wr_en  = commit && wr_ok;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            m_reg_wr_o <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                m_reg_wr_o[i] <= wr_en && (aw_idx == ADDR_WIDTH'(i));
                if (wr_en && (aw_idx == ADDR_WIDTH'(i))) begin
                    regs[i] <= DATA_WIDTH'(byte_merge(MAX_DW'(regs[i]),
                                                      MAX_DW'(w_data),
                                                      MAX_SW'(w_strb)));
                end
            end
        end
    end

    assign m_regs_o = regs;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            b_valid <= 1'b0;
            b_id    <= '0;
            b_resp  <= OKAY;
        end else if (commit) begin
            b_valid <= 1'b1;
            b_id    <= aw_id;
            b_resp  <= wr_ok ? OKAY : SLVERR;
        end else if (s_axi.bready_i) begin
            b_valid <= 1'b0;
        end
    end

    assign s_axi.bvalid_o = b_valid;
    assign s_axi.bid_o    = b_id;
    assign s_axi.bresp_o  = b_resp;

`ifdef S_AXI_REGBANK_CSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            csum = DATA_WIDTH'(csum_fold(MAX_DW'(csum), MAX_DW'(regs[i])));
        end
    end
`endif

    assign ar_idx = s_axi.araddr_i >> SHIFT;

    always_comb begin
        rd_data = '0;
        rd_resp = SLVERR;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (ar_idx == ADDR_WIDTH'(i)) begin
                rd_data = regs[i];
                rd_resp = OKAY;
            end
        end
`ifdef S_AXI_REGBANK_CSUM_EN
        if (ar_idx == ADDR_WIDTH'(REG_COUNT)) begin
            rd_data = csum;
            rd_resp = OKAY;
        end
`endif
    end

    assign s_axi.arready_o = !areset && (!r_valid || s_axi.rready_i);
    assign ar_hs           = s_axi.arvalid_i && s_axi.arready_o;

    // Sampling regs before the edge gives pre-write data on a same-edge commit.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_resp  <= OKAY;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_last  <= 1'b1;
            r_id    <= s_axi.arid_i;
            r_data  <= rd_data;
            r_resp  <= rd_resp;
        end else if (s_axi.rready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign s_axi.rvalid_o = r_valid;
    assign s_axi.rlast_o  = r_last;
    assign s_axi.rid_o    = r_id;
    assign s_axi.rdata_o  = r_data;
    assign s_axi.rresp_o  = r_resp;
endmodule
